// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - load/store alignment engine with optional two-beat split of misaligned accesses
// Optional feature macro: MEM_ALIGN_SPLIT_EN (undefined: misaligned accesses trap with resp_err)
module mem_align_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [6:0]            req_opcode,
    input  logic [2:0]            req_funct,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int W2    = 2 * DATA_W;
    localparam int BE2   = 2 * BE_W;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic              r_is_load, r_split;
    logic [2:0]        r_funct;
    logic [OFF_W-1:0]  r_off;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wide_hi, r_rdata0, r_rdata1;
    logic [BE_W-1:0]   r_mask_hi;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [BE_W-1:0]   r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [31:0]       r_resp_data;
    logic              r_resp_err;

    logic              w_accept, w_is_load, w_is_store, w_funct_ok, w_split, w_err;
    logic [OFF_W-1:0]  w_off;
    logic [2:0]        w_size;
    logic [4:0]        w_end;
    logic [ADDR_W-1:0] w_base;
    logic [W2-1:0]     w_wide;
    logic [BE2-1:0]    w_mask;
    logic [DATA_W-1:0] w_rd0, w_rd1;
    logic [31:0]       w_ld_w, w_ld_ext;

    always_comb begin
        w_accept   = req_valid && (r_state == S_IDLE);
        w_is_load  = (req_opcode == OPC_LOAD);
        w_is_store = (req_opcode == OPC_STORE);
        w_off      = req_addr[OFF_W-1:0];
        w_base     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        case (req_funct[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        w_end   = 5'(w_off) + 5'(w_size);
        w_split = (w_end > 5'(BE_W));
        if (w_is_load)
            w_funct_ok = req_funct inside {FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU};
        else if (w_is_store)
            w_funct_ok = req_funct inside {FNC_LB, FNC_LH, FNC_LW};
        else
            w_funct_ok = 1'b0;
`ifdef MEM_ALIGN_SPLIT_EN
        w_err = !w_funct_ok;
`else
        w_err = !w_funct_ok || w_split;
`endif
        // Both beats' lanes are built over a double-width window; beat1 takes the upper halves
        w_wide = W2'(req_wdata) << {w_off, 3'b000};
        w_mask = BE2'((32'd1 << w_size) - 32'd1) << w_off;
    end

    // Read data is used in the same cycle it is captured, so bypass the capture registers
    always_comb begin
        w_rd0  = (r_state == S_WAIT0) ? mem_rdata : r_rdata0;
        w_rd1  = (r_state == S_WAIT1) ? mem_rdata : r_rdata1;
        w_ld_w = 32'({w_rd1, w_rd0} >> {r_off, 3'b000});
        case (r_funct)
            FNC_LB:  w_ld_ext = {{24{w_ld_w[7]}}, w_ld_w[7:0]};
            FNC_LH:  w_ld_ext = {{16{w_ld_w[15]}}, w_ld_w[15:0]};
            FNC_LBU: w_ld_ext = {24'd0, w_ld_w[7:0]};
            FNC_LHU: w_ld_ext = {16'd0, w_ld_w[15:0]};
            default: w_ld_ext = w_ld_w;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = w_err ? S_DONE : S_REQ0;
            S_REQ0:  if (mem_req_ready)
                         w_state_nxt = r_is_load ? S_WAIT0 : (r_split ? S_REQ1 : S_DONE);
            S_WAIT0: if (mem_rvalid) w_state_nxt = r_split ? S_REQ1 : S_DONE;
            S_REQ1:  if (mem_req_ready) w_state_nxt = r_is_load ? S_WAIT1 : S_DONE;
            S_WAIT1: if (mem_rvalid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_load <= w_is_load;
            r_funct   <= req_funct;
            r_off     <= w_off;
            r_split   <= w_split;
            r_base    <= w_base;
            r_wide_hi <= w_wide[W2-1:DATA_W];
            r_mask_hi <= w_mask[BE2-1:BE_W];
        end
        if (r_state == S_WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
        if (r_state == S_WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= '0;
            r_mem_wdata     <= '0;
            r_resp_data     <= '0;
            r_resp_err      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_mem_req_valid <= (w_state_nxt == S_REQ0) || (w_state_nxt == S_REQ1);
            if (r_state == S_IDLE && w_state_nxt == S_REQ0) begin
                r_mem_addr  <= w_base;
                r_mem_we    <= w_is_load ? '0 : w_mask[BE_W-1:0];
                r_mem_wdata <= w_wide[DATA_W-1:0];
            end else if (r_state != S_REQ1 && w_state_nxt == S_REQ1) begin
                r_mem_addr  <= r_base + ADDR_W'(BE_W);
                r_mem_we    <= r_is_load ? '0 : r_mask_hi;
                r_mem_wdata <= r_wide_hi;
            end else if (w_state_nxt != S_REQ0 && w_state_nxt != S_REQ1) begin
                r_mem_we <= '0;
            end
            // Loads reach DONE only from a WAIT state; entry straight from IDLE is an error
            if (r_state != S_DONE && w_state_nxt == S_DONE) begin
                r_resp_data <= (r_state == S_WAIT0 || r_state == S_WAIT1) ? w_ld_ext : 32'd0;
                r_resp_err  <= (r_state == S_IDLE);
            end else if (w_state_nxt == S_IDLE) begin
                r_resp_data <= '0;
                r_resp_err  <= 1'b0;
            end
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_DONE);
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;
    assign resp_data     = r_resp_data;
    assign resp_err      = r_resp_err;
endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - directed self-checking bench for mem_align_unit (DATA_W=32)
module tb_mem_align_unit;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    mem_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int          nb, lat, unstable;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_we [2];
    logic [31:0] r_data;
    logic        r_err;
    logic        got_resp;

    task automatic run_access(input string tag, input logic [6:0] opc, input logic [2:0] fn,
                              input logic [31:0] addr, input logic [31:0] wd, input int stall,
                              input logic [31:0] rd0, input logic [31:0] rd1);
        int          t0, stall_left;
        logic        rd_pend, snap, is_load;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_we;
        nb = 0; lat = 0; unstable = 0; got_resp = 0; r_data = '0; r_err = 1'b0;
        rd_pend = 0; snap = 0; stall_left = stall; is_load = (opc == OPC_LOAD);
        s_addr = '0; s_wdata = '0; s_we = '0;
        mem_req_ready = (stall == 0);
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1; req_opcode = opc; req_funct = fn; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        t0 = cyc;
        req_valid = 1'b0;
        for (int k = 0; k < 40 && !got_resp; k++) begin
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                got_resp = 1'b1; r_data = resp_data; r_err = resp_err; lat = cyc - t0 + 1;
            end else begin
                if (rd_pend) begin
                    mem_rvalid = 1'b1; mem_rdata = (nb == 1) ? rd0 : rd1; rd_pend = 1'b0;
                end
                if (mem_req_valid) begin
                    if (!snap) begin
                        snap = 1'b1; s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
                    end else if (nb == 0 && (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata)) begin
                        unstable++;
                    end
                    if (stall_left > 0) begin
                        mem_req_ready = 1'b0; stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                        if (nb < 2) begin
                            b_addr[nb] = mem_addr; b_we[nb] = mem_we; b_wdata[nb] = mem_wdata;
                        end
                        nb++;
                        rd_pend = is_load;
                    end
                end
                @(posedge clk); #1;
            end
        end
        mem_rvalid = 1'b0; mem_req_ready = 1'b1;
        check({tag, "_resp_seen"}, 64'(got_resp), 64'd1);
    endtask

    int seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_resp", 64'({resp_valid, resp_err, resp_data}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_access("lw", OPC_LOAD, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
        check("lw_beats", 64'(nb), 64'd1);
        check("lw_addr", 64'(b_addr[0]), 64'h100);
        check("lw_we", 64'(b_we[0]), 64'h0);
        check("lw_data", 64'(r_data), 64'hDEADBEEF);
        check("lw_err", 64'(r_err), 64'd0);

        run_access("lb", OPC_LOAD, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000, 32'h0);
        check("lb_addr", 64'(b_addr[0]), 64'h100);
        check("lb_data", 64'(r_data), 64'hFFFFFF80);
        run_access("lbu", OPC_LOAD, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000, 32'h0);
        check("lbu_data", 64'(r_data), 64'h00000080);
        run_access("lh", OPC_LOAD, 3'b001, 32'h102, 32'h0, 0, 32'h80010000, 32'h0);
        check("lh_data", 64'(r_data), 64'hFFFF8001);
        run_access("lhu", OPC_LOAD, 3'b101, 32'h102, 32'h0, 0, 32'h80010000, 32'h0);
        check("lhu_data", 64'(r_data), 64'h00008001);

        run_access("sh", OPC_STORE, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0, 32'h0);
        check("sh_beats", 64'(nb), 64'd1);
        check("sh_addr", 64'(b_addr[0]), 64'h100);
        check("sh_we", 64'(b_we[0]), 64'b1100);
        check("sh_wdata", 64'(b_wdata[0]), 64'hABCD0000);
        check("sh_lat", 64'(lat), 64'd2);
        check("sh_resp", 64'({r_err, r_data}), 64'd0);

        run_access("sb", OPC_STORE, 3'b000, 32'h101, 32'h11223377, 0, 32'h0, 32'h0);
        check("sb_we", 64'(b_we[0]), 64'b0010);
        check("sb_wdata", 64'(b_wdata[0]), 64'h22337700);

        run_access("sw_split", OPC_STORE, 3'b010, 32'h1FE, 32'hAABBCCDD, 0, 32'h0, 32'h0);
`ifdef MEM_ALIGN_SPLIT_EN
        check("sw_split_beats", 64'(nb), 64'd2);
        check("sw_split_addr0", 64'(b_addr[0]), 64'h1FC);
        check("sw_split_we0", 64'(b_we[0]), 64'b1100);
        check("sw_split_wdata0", 64'(b_wdata[0]), 64'hCCDD0000);
        check("sw_split_addr1", 64'(b_addr[1]), 64'h200);
        check("sw_split_we1", 64'(b_we[1]), 64'b0011);
        check("sw_split_wdata1", 64'(b_wdata[1]), 64'h0000AABB);
        check("sw_split_lat", 64'(lat), 64'd3);
        check("sw_split_err", 64'(r_err), 64'd0);
`else
        check("sw_split_beats", 64'(nb), 64'd0);
        check("sw_split_err", 64'(r_err), 64'd1);
        check("sw_split_data", 64'(r_data), 64'd0);
`endif

        run_access("lh_split", OPC_LOAD, 3'b001, 32'h3, 32'h0, 3, 32'h80000000, 32'h000000F1);
        check("lh_split_stable", 64'(unstable), 64'd0);
`ifdef MEM_ALIGN_SPLIT_EN
        check("lh_split_beats", 64'(nb), 64'd2);
        check("lh_split_addr0", 64'(b_addr[0]), 64'h0);
        check("lh_split_addr1", 64'(b_addr[1]), 64'h4);
        check("lh_split_we", 64'({b_we[0], b_we[1]}), 64'h0);
        check("lh_split_data", 64'(r_data), 64'hFFFFF180);
        run_access("lh_wrap", OPC_LOAD, 3'b001, 32'hFFFFFFFF, 32'h0, 0, 32'hAB000000, 32'h000000CD);
        check("lh_wrap_addr1", 64'(b_addr[1]), 64'h0);
        check("lh_wrap_data", 64'(r_data), 64'hFFFFCDAB);
`else
        check("lh_split_beats", 64'(nb), 64'd0);
        check("lh_split_err", 64'(r_err), 64'd1);
`endif

        run_access("bad_opc", 7'h33, 3'b000, 32'h100, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
        check("bad_opc_beats", 64'(nb), 64'd0);
        check("bad_opc_resp", 64'({r_err, r_data}), 64'h1_0000_0000);
        run_access("bad_fn", OPC_STORE, 3'b100, 32'h100, 32'hFFFFFFFF, 0, 32'h0, 32'h0);
        check("bad_fn_beats", 64'(nb), 64'd0);
        check("bad_fn_err", 64'(r_err), 64'd1);

        mem_req_ready = 1'b1;
        req_valid = 1'b1; req_opcode = OPC_LOAD; req_funct = 3'b010; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait0_no_beat", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (resp_valid) seen++;
        end
        check("late_rvalid_no_resp", 64'(seen), 64'd0);
        check("late_rvalid_idle", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
